// File: rtl/npu_mem_pkg.sv
// Shared types for the NPU frame-RAM producer path.
// The RAM is 2**ADDR_W bytes deep and is written through port B.
package npu_mem_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, FIN} wr_state_t;

  typedef logic [ADDR_W-1:0] ram_addr_t;

endpackage

// File: rtl/ram_stream_writer.sv
// Streams bytes from a valid/ready source into sequential frame-RAM locations
// via port B, then reports done / error / aborted as 1-cycle pulses.
//
// state | meaning
// IDLE  | waiting for start; range check and length==0 handled here
// RUN   | accepting bytes, one registered RAM write per accepted byte
// FIN   | done pulse, coincides with the final ram_wren
module ram_stream_writer
  import npu_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              aborted
);

  localparam logic [ADDR_W+1:0] RAM_SIZE = (ADDR_W+2)'(1) << ADDR_W;

  wr_state_t         state_q;
  wr_state_t         state_d;
  ram_addr_t         addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W+1:0] end_addr;
  logic              overflow;
  logic              cmd_ok;
  logic              accept;
  logic              last_byte;

  // One extra bit over the range-check width so base+length cannot itself wrap.
  assign end_addr  = {2'b00, base_addr} + {1'b0, length};
  assign overflow  = end_addr > RAM_SIZE;
  assign cmd_ok    = (state_q == IDLE) && start && !overflow;
  assign accept    = s_valid && s_ready;
  assign last_byte = rem_q == (ADDR_W+1)'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_ok) begin
          state_d = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept && last_byte) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      RUN: begin
        s_ready = !abort;
        busy    = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      rem_q       <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      error       <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      error    <= (state_q == IDLE) && start && overflow;
      aborted  <= (state_q == RUN) && abort;
      ram_wren <= accept;
      if (cmd_ok) begin
        addr_q <= base_addr;
        rem_q  <= length;
      end else if (accept) begin
        addr_q      <= addr_q + 1'b1;
        rem_q       <= rem_q - 1'b1;
        ram_address <= addr_q;
        ram_data    <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed bench for ram_stream_writer: a negedge monitor logs RAM writes and
// pulses, and each scenario checks them against hand-computed values.
module tb_ram_stream_writer;
  import npu_mem_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              busy;
  logic              done;
  logic              error;
  logic              aborted;

  ram_stream_writer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .abort       (abort),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .aborted     (aborted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: stands in for the RAM (port A read-back) and logs every pulse.
  int                cyc = 0;
  logic              prev_acc = 1'b0;
  int                lat_err = 0;
  int                done_cnt = 0;
  int                done_wren_cnt = 0;
  int                err_cnt = 0;
  int                abt_cnt = 0;
  int                busy_cnt = 0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int                wc_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      if (ram_wren) begin
        wa_q.push_back(ram_address);
        wd_q.push_back(ram_data);
        wc_q.push_back(cyc);
        mem[ram_address] = ram_data;
      end
      if (ram_wren !== prev_acc) lat_err++;
      if (done) done_cnt++;
      if (done && ram_wren) done_wren_cnt++;
      if (error) err_cnt++;
      if (aborted) abt_cnt++;
      if (busy) busy_cnt++;
      prev_acc = s_valid && s_ready;
    end else begin
      prev_acc = 1'b0;
    end
  end

  int w0, d0, dw0, e0, a0, b0;
  logic [DATA_W-1:0] pat [8];

  task automatic snap();
    w0  = wa_q.size();
    d0  = done_cnt;
    dw0 = done_wren_cnt;
    e0  = err_cnt;
    a0  = abt_cnt;
    b0  = busy_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    @(posedge clock); #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Presents pat[0..n-1]; toggle alternates s_valid, abort_at>0 raises abort
  // on the cycle of that (1-based) accept, restart_at>=0 pulses a stray start.
  task automatic run_stream(input int n, input bit toggle, input int abort_at, input int restart_at);
    int  idx = 0;
    int  cnt = 0;
    bit  ph  = 1'b1;
    bit  ab  = 1'b0;
    while (idx < n && cnt < 200 && !ab) begin
      @(posedge clock); #1;
      s_valid = toggle ? ph : 1'b1;
      ph      = ~ph;
      s_data  = pat[idx];
      abort   = (abort_at > 0) && (idx == abort_at - 1) && s_valid;
      start   = (restart_at >= 0) && (idx == restart_at);
      if (start) begin
        base_addr = 19'h00500;
        length    = 20'd2;
      end
      @(negedge clock);
      ab = abort;
      if (s_valid && s_ready) idx++;
      cnt++;
    end
    @(posedge clock); #1;
    s_valid = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
    check("stream_progress", idx, (abort_at > 0) ? abort_at - 1 : n);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    abort     = 1'b0;
    s_valid   = 1'b1;
    s_data    = 8'h5A;

    // 1 reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_outputs", {s_ready, ram_address, ram_data, ram_wren, busy, done, error, aborted}, '0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready_idle", s_ready, 1'b0);
    check("rst_outputs_post", {ram_address, ram_data, ram_wren, busy, done, error, aborted}, '0);
    @(posedge clock); #1;
    s_valid = 1'b0;

    // 2 basic
    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    snap();
    do_start(19'h00010, 20'd4);
    run_stream(4, 1'b0, 0, -1);
    idle(3);
    check("basic_wr_cnt", wa_q.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_addr%0d", i), wa_q[w0+i], 19'h00010 + 19'(i));
      check($sformatf("basic_data%0d", i), wd_q[w0+i], pat[i]);
      check($sformatf("basic_rdback%0d", i), mem[19'h00010 + 19'(i)], pat[i]);
    end
    check("basic_back2back", wc_q[w0+3] - wc_q[w0], 3);
    check("basic_done_cnt", done_cnt - d0, 1);
    check("basic_done_on_wren", done_wren_cnt - dw0, 1);

    // 3 backpressure
    snap();
    do_start(19'h00020, 20'd4);
    run_stream(4, 1'b1, 0, -1);
    idle(3);
    check("bp_wr_cnt", wa_q.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_addr%0d", i), wa_q[w0+i], 19'h00020 + 19'(i));
      check($sformatf("bp_data%0d", i), wd_q[w0+i], pat[i]);
    end
    check("bp_done_cnt", done_cnt - d0, 1);
    check("bp_done_on_wren", done_wren_cnt - dw0, 1);

    // 4 boundaries
    snap();
    do_start(19'h00100, 20'd0);
    idle(3);
    check("len0_wr_cnt", wa_q.size() - w0, 0);
    check("len0_done_cnt", done_cnt - d0, 1);
    check("len0_busy", busy_cnt - b0, 0);

    pat[0] = 8'h11; pat[1] = 8'h22;
    snap();
    do_start(19'h7FFFE, 20'd2);
    run_stream(2, 1'b0, 0, -1);
    idle(3);
    check("top_wr_cnt", wa_q.size() - w0, 2);
    check("top_addr0", wa_q[w0], 19'h7FFFE);
    check("top_addr1", wa_q[w0+1], 19'h7FFFF);
    check("top_data1", wd_q[w0+1], 8'h22);
    check("top_done_cnt", done_cnt - d0, 1);

    snap();
    do_start(19'h7FFFF, 20'd2);
    idle(3);
    check("ovf_err_cnt", err_cnt - e0, 1);
    check("ovf_wr_cnt", wa_q.size() - w0, 0);
    check("ovf_busy", busy_cnt - b0, 0);
    check("ovf_done_cnt", done_cnt - d0, 0);

    snap();
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    idle(2);
    check("idle_abort_ignored", abt_cnt - a0, 0);

    // 5 abort
    for (int i = 0; i < 8; i++) pat[i] = 8'h30 + 8'(i);
    snap();
    do_start(19'h00200, 20'd8);
    run_stream(8, 1'b0, 3, -1);
    @(negedge clock);
    check("abt_busy_after", busy, 1'b0);
    idle(3);
    check("abt_wr_cnt", wa_q.size() - w0, 2);
    check("abt_addr1", wa_q[w0+1], 19'h00201);
    check("abt_pulse_cnt", abt_cnt - a0, 1);
    check("abt_done_cnt", done_cnt - d0, 0);

    pat[0] = 8'h9C;
    snap();
    do_start(19'h00300, 20'd1);
    run_stream(1, 1'b0, 0, -1);
    idle(3);
    check("post_abt_wr_cnt", wa_q.size() - w0, 1);
    check("post_abt_addr", wa_q[w0], 19'h00300);
    check("post_abt_data", wd_q[w0], 8'h9C);
    check("post_abt_done", done_cnt - d0, 1);

    // 6 start ignored while running
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h03; pat[3] = 8'h04;
    snap();
    do_start(19'h00400, 20'd4);
    run_stream(4, 1'b0, 0, 1);
    idle(4);
    check("ign_wr_cnt", wa_q.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ign_addr%0d", i), wa_q[w0+i], 19'h00400 + 19'(i));
    end
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_err_cnt", err_cnt - e0, 0);

    check("wren_latency_errs", lat_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
